// File: rtl/frame_deserializer.sv
// ---------------------------------------------------------------------------
// frame_deserializer
//
// Receive-side framer. Collects a bit-serial FEC frame from the link and
// presents it as DATA_DEPTH x DATA_WIDTH words for the unscrambler.
//
// Two frame formats are supported, selected by enc_used at frame start:
//   format0 : DATA_DEPTH rows x DATA_WIDTH bits (80 bits by default)
//   format1 : F1_ROWS rows x F1_WIDTH bits (24 bits by default). Unused row
//             bits and unused rows are delivered as zero.
// Bit order on the wire: row 0 first, rows ascending, each row LSB first.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   enc_used     format select (0 = format0, 1 = format1), sampled at frame start
//   ser_in       serial data bit
//   ser_valid    ser_in is valid this cycle
//   frame_start  with ser_valid: this bit is bit 0 of a frame
//   par_out      assembled frame, held between frames
//   par_valid    1-cycle pulse when par_out/fmt_out are updated
//   fmt_out      format of the frame currently held on par_out
//   busy         a frame is being received
//   frame_err    1-cycle pulse when a frame is aborted (restart or timeout)
// ---------------------------------------------------------------------------
module frame_deserializer #(
  parameter int DATA_WIDTH     = 10,
  parameter int DATA_DEPTH     = 8,
  parameter int F1_ROWS        = 4,
  parameter int F1_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enc_used,
  input  logic                                  ser_in,
  input  logic                                  ser_valid,
  input  logic                                  frame_start,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out,
  output logic                                  par_valid,
  output logic                                  fmt_out,
  output logic                                  busy,
  output logic                                  frame_err
);

  localparam int RW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [RW-1:0] F0_ROW_LAST = RW'(DATA_DEPTH - 1);
  localparam logic [CW-1:0] F0_COL_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [RW-1:0] F1_ROW_LAST = RW'(F1_ROWS - 1);
  localparam logic [CW-1:0] F1_COL_LAST = CW'(F1_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                               state;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow_nxt;
  logic [RW-1:0]                        row_cnt;
  logic [CW-1:0]                        col_cnt;
  logic [GW-1:0]                        gap_cnt;
  logic                                 fmt_lat;

  logic start;
  logic accept;
  logic row_end;
  logic last_bit;

  // A frame_start is honoured in any state; in RECV it aborts the current frame.
  assign start    = ser_valid & frame_start;
  assign accept   = ser_valid & ~frame_start & (state == RECV);
  assign row_end  = (col_cnt == (fmt_lat ? F1_COL_LAST : F0_COL_LAST));
  assign last_bit = row_end & (row_cnt == (fmt_lat ? F1_ROW_LAST : F0_ROW_LAST));

  // Next shadow contents. A new frame starts from a cleared shadow so that
  // unused format1 bits/rows come out as zero. Completion copies shadow_nxt
  // to par_out so the last bit lands on the same edge it is accepted.
  always_comb begin
    shadow_nxt = shadow;
    if (start) begin
      shadow_nxt       = '0;
      shadow_nxt[0][0] = ser_in;
    end else if (accept) begin
      shadow_nxt[row_cnt][col_cnt] = ser_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      gap_cnt   <= '0;
      fmt_lat   <= 1'b0;
      par_out   <= '0;
      par_valid <= 1'b0;
      fmt_out   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      shadow    <= shadow_nxt;

      if (start) begin
        // Bit 0 of a new frame; a frame already in flight is discarded.
        if (state == RECV) frame_err <= 1'b1;
        state   <= RECV;
        busy    <= 1'b1;
        fmt_lat <= enc_used;
        row_cnt <= '0;
        col_cnt <= CW'(1);
        gap_cnt <= '0;
      end else if (state == RECV) begin
        if (ser_valid) begin
          gap_cnt <= '0;
          if (last_bit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            par_out   <= shadow_nxt;
            fmt_out   <= fmt_lat;
            par_valid <= 1'b1;
            row_cnt   <= '0;
            col_cnt   <= '0;
          end else if (row_end) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end else if (gap_cnt == GAP_LAST) begin
          // Link went quiet too long: drop the frame, keep the last good par_out.
          frame_err <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
          gap_cnt   <= '0;
          row_cnt   <= '0;
          col_cnt   <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule
